phase_accumulator: RTL and testbench

- Numerically-controlled phase generator that sits directly upstream of sine_wavetable.
- Advances an ACC_W-bit phase accumulator by a programmable frequency increment once per sample tick.
- Presents the top PHASE_W bits as the registered wavetable phase address.
- Generates its own sample-rate strobe from the system clock and accepts glitch-free increment updates through a valid/ready handshake.

---
 rtl/phase_accumulator.sv | 130 +++++++++++++
 tb/tb_phase_accumulator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator.sv
// Numerically-controlled phase generator feeding sine_wavetable with a registered phase address.
// Optional hard-sync input enabled by defining PHASE_ACC_SYNC_EN.
module phase_accumulator #(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned PHASE_W    = 8,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ACC_W-1:0]   inc,
  input  logic               inc_valid,
  output logic               inc_ready,
`ifdef PHASE_ACC_SYNC_EN
  input  logic               sync,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap
);

  localparam int unsigned      CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  // Single-entry increment buffer: EMPTY accepts, PENDING waits for the next tick.
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } buf_state_e;

  buf_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   active_inc_q, active_inc_d;
  logic [ACC_W-1:0]   pending_inc_q, pending_inc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;

  logic               tick_c;
  logic               accept_c;
  logic               sync_c;
  logic               carry_c;
  logic [ACC_W:0]     sum_c;

`ifdef PHASE_ACC_SYNC_EN
  assign sync_c = sync;
`else
  assign sync_c = 1'b0;
`endif

  assign tick_c    = enable && (cnt_q == CNT_LAST);
  assign inc_ready = (state_q == ST_EMPTY) && !reset;
  assign accept_c  = inc_valid && inc_ready;
  assign sum_c     = {1'b0, acc_q} + {1'b0, active_inc_q};

  // Buffer state: an accepted increment stays pending until the next tick hands it over.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY:   if (accept_c) state_d = ST_PENDING;
      ST_PENDING: if (tick_c)   state_d = ST_EMPTY;
      default:    state_d = ST_EMPTY;
    endcase
  end

  // Sample-rate counter, accumulator datapath and registered outputs.
  always_comb begin
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    carry_c       = 1'b0;
    active_inc_d  = active_inc_q;
    pending_inc_d = pending_inc_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;

    if (enable) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (tick_c) begin
      if (sync_c) begin
        acc_d   = '0;
        carry_c = 1'b1;
      end else begin
        acc_d   = sum_c[ACC_W-1:0];
        carry_c = sum_c[ACC_W];
      end
      // Handover after the add so a new increment first affects the following tick.
      if (state_q == ST_PENDING) begin
        active_inc_d = pending_inc_q;
      end
      phase_d       = acc_d[ACC_W-1 -: PHASE_W];
      phase_valid_d = 1'b1;
      wrap_d        = carry_c;
    end

    if (accept_c) begin
      pending_inc_d = inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      cnt_q         <= '0;
      acc_q         <= '0;
      active_inc_q  <= '0;
      pending_inc_q <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      active_inc_q  <= active_inc_d;
      pending_inc_q <= pending_inc_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: reference model feeds a scoreboard of expected phase pulses.
module tb_phase_accumulator;

  localparam int unsigned ACC_W      = 32;
  localparam int unsigned PHASE_W    = 8;
  localparam int unsigned SAMPLE_DIV = 4;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic               wrap;
  } exp_t;

  logic               clk       = 1'b0;
  logic               reset     = 1'b1;
  logic               enable    = 1'b0;
  logic [ACC_W-1:0]   inc       = '0;
  logic               inc_valid = 1'b0;
  logic               inc_ready;
`ifdef PHASE_ACC_SYNC_EN
  logic               sync      = 1'b0;
`endif
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic               wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int                 m_cnt   = 0;
  logic [ACC_W-1:0]   m_acc   = '0;
  logic [ACC_W-1:0]   m_act   = '0;
  logic [ACC_W-1:0]   m_pinc  = '0;
  logic               m_pend  = 1'b0;
  logic               m_pv    = 1'b0;
  logic               m_wrap  = 1'b0;
  logic [PHASE_W-1:0] m_phase = '0;
  logic               m_tick;
  logic               m_acc_ok;
  logic [ACC_W:0]     m_sum;

  exp_t               sb[$];
  logic [PHASE_W-1:0] seen[$];
  int                 wrap_cnt   = 0;
  logic [PHASE_W-1:0] wrap_phase = '0;
  int                 acc_cnt    = 0;

  phase_accumulator #(
    .ACC_W      (ACC_W),
    .PHASE_W    (PHASE_W),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .inc         (inc),
    .inc_valid   (inc_valid),
    .inc_ready   (inc_ready),
`ifdef PHASE_ACC_SYNC_EN
    .sync        (sync),
`endif
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int c);
    int guard = 0;
    while (m_cnt != c && guard < 16) begin
      run(1);
      guard++;
    end
    if (guard >= 16) check("wait_cnt_timeout", 64'(guard), 64'(0));
  endtask

  // Behavioural model of one clock edge; pushes the expected pulse on every tick.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_acc = '0; m_act = '0; m_pinc = '0; m_pend = 1'b0;
      m_pv = 1'b0; m_wrap = 1'b0; m_phase = '0;
      sb.delete();
    end else begin
      m_tick   = enable && (m_cnt == int'(SAMPLE_DIV) - 1);
      m_acc_ok = inc_valid && !m_pend;
      m_pv     = m_tick;
      m_wrap   = 1'b0;
      if (m_tick) begin
        m_sum = {1'b0, m_acc} + {1'b0, m_act};
`ifdef PHASE_ACC_SYNC_EN
        if (sync) m_sum = {1'b1, {ACC_W{1'b0}}};
`endif
        m_acc   = m_sum[ACC_W-1:0];
        m_wrap  = m_sum[ACC_W];
        m_phase = m_acc[ACC_W-1 -: PHASE_W];
        sb.push_back('{phase: m_phase, wrap: m_wrap});
        if (m_pend) begin
          m_act  = m_pinc;
          m_pend = 1'b0;
        end
      end
      if (m_acc_ok) begin
        m_pinc = inc;
        m_pend = 1'b1;
      end
      if (enable) m_cnt = m_tick ? 0 : m_cnt + 1;
    end
  end

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    check("inc_ready", 64'(inc_ready), 64'(!m_pend && !reset));
    check("phase_valid", 64'(phase_valid), 64'(m_pv));
    if (phase_valid) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("phase", 64'(phase), 64'(e.phase));
        check("wrap", 64'(wrap), 64'(e.wrap));
      end
      seen.push_back(phase);
      if (wrap) begin
        wrap_cnt++;
        wrap_phase = phase;
      end
    end else begin
      check("phase_hold", 64'(phase), 64'(m_phase));
      check("wrap_idle", 64'(wrap), 64'(0));
    end
    if (inc_valid && inc_ready) acc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [PHASE_W-1:0] n;

    // Reset state.
    run(3);
    check("rst_phase", 64'(phase), 64'(0));
    check("rst_pv", 64'(phase_valid), 64'(0));
    check("rst_wrap", 64'(wrap), 64'(0));
    check("rst_ready", 64'(inc_ready), 64'(0));

    // First increment: first tick still uses zero, then +1 per tick.
    reset = 1'b0; enable = 1'b1; inc = 32'h0100_0000; inc_valid = 1'b1;
    seen.delete();
    #1 check("t1_ready_open", 64'(inc_ready), 64'(1));
    run(1);
    inc_valid = 1'b0; inc = 32'hDEAD_BEEF;
    #1 check("t1_ready_held", 64'(inc_ready), 64'(0));
    run(40);
    check("t1_pulses", 64'(seen.size()), 64'(10));
    check("t1_ph0", 64'(seen[0]), 64'(8'h00));
    check("t1_ph1", 64'(seen[1]), 64'(8'h01));
    check("t1_ph2", 64'(seen[2]), 64'(8'h02));
    check("t1_ph9", 64'(seen[9]), 64'(8'h09));

    // 256 ticks: exactly one wrap, landing on phase 0.
    seen.delete(); wrap_cnt = 0;
    run(256 * SAMPLE_DIV);
    check("t2_pulses", 64'(seen.size()), 64'(256));
    check("t2_wraps", 64'(wrap_cnt), 64'(1));
    check("t2_wrap_phase", 64'(wrap_phase), 64'(0));

    // Offer on the tick cycle: that tick and the next still use +1, then +2.
    wait_cnt(int'(SAMPLE_DIV) - 1);
    n = m_phase;
    check("t3_ready", 64'(inc_ready), 64'(1));
    inc = 32'h0200_0000; inc_valid = 1'b1;
    seen.delete();
    run(1);
    inc_valid = 1'b0;
    run(11);
    check("t3_pulses", 64'(seen.size()), 64'(3));
    check("t3_ph0", 64'(seen[0]), 64'(8'(n + 8'd1)));
    check("t3_ph1", 64'(seen[1]), 64'(8'(n + 8'd2)));
    check("t3_ph2", 64'(seen[2]), 64'(8'(n + 8'd4)));

    // Streaming offers: one accept per tick period.
    wait_cnt(0);
    acc_cnt = 0;
    inc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inc = 32'(i + 5) << 24;
      run(1);
    end
    inc_valid = 1'b0;
    check("t4_accepts", 64'(acc_cnt), 64'(4));
    run(8);

    // Enable gap mid-period: no pulses, counter resumes from frozen value.
    wait_cnt(1);
    enable = 1'b0;
    seen.delete();
    run(10);
    check("t5_gap_pulses", 64'(seen.size()), 64'(0));
    enable = 1'b1;
    seen.delete();
    run(2);
    check("t5_resume_early", 64'(seen.size()), 64'(0));
    run(2);
    check("t5_resume_tick", 64'(seen.size()), 64'(1));

    // Reset with a pending increment discards it.
    wait_cnt(0);
    inc = 32'h0700_0000; inc_valid = 1'b1;
    run(1);
    inc_valid = 1'b0;
    check("t6_pending", 64'(inc_ready), 64'(0));
    reset = 1'b1;
    #1 check("t6_ready_in_rst", 64'(inc_ready), 64'(0));
    run(1);
    check("t6_rst_phase", 64'(phase), 64'(0));
    check("t6_rst_pv", 64'(phase_valid), 64'(0));
    check("t6_rst_wrap", 64'(wrap), 64'(0));
    run(1);
    reset = 1'b0;
    #1 check("t6_ready_after", 64'(inc_ready), 64'(1));
    seen.delete();
    run(3);
    check("t6_no_early_tick", 64'(seen.size()), 64'(0));
    run(2);
    check("t6_first_tick", 64'(seen.size()), 64'(1));
    run(4);
    check("t6_two_ticks", 64'(seen.size()), 64'(2));
    check("t6_ph1_zero", 64'(seen[1]), 64'(0));

    // Maximum increment behaves as -1.
    inc = '1; inc_valid = 1'b1;
    run(1);
    inc_valid = 1'b0;
    run(12 * SAMPLE_DIV);

`ifdef PHASE_ACC_SYNC_EN
    // Hard sync on the third tick forces phase 0 with wrap.
    reset = 1'b1;
    run(2);
    reset = 1'b0; inc = 32'h1000_0000; inc_valid = 1'b1;
    run(1);
    inc_valid = 1'b0;
    wait_cnt(int'(SAMPLE_DIV) - 1);
    run(1);
    for (int k = 0; k < 4; k++) begin
      wait_cnt(int'(SAMPLE_DIV) - 1);
      if (k == 0) begin
        seen.delete();
        wrap_cnt = 0;
      end
      sync = (k == 2);
      run(1);
      sync = 1'b0;
    end
    run(1);
    check("t7_pulses", 64'(seen.size()), 64'(4));
    check("t7_ph0", 64'(seen[0]), 64'(8'h10));
    check("t7_ph1", 64'(seen[1]), 64'(8'h20));
    check("t7_ph2", 64'(seen[2]), 64'(8'h00));
    check("t7_ph3", 64'(seen[3]), 64'(8'h10));
    check("t7_wraps", 64'(wrap_cnt), 64'(1));
    wait_cnt(1);
    sync = 1'b1;
    run(1);
    sync = 1'b0;
    run(8);
`endif

    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
